dpram_sc: RTL and testbench

DPRAM_SC -- requirements
Module: dpram_sc

---
 rtl/dpram_sc.sv | 160 ++++++++++++++++
 tb/tb_dpram_sc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_sc.sv
// rtl/dpram_sc.sv - single-clock true dual-port RAM with byte lanes, write modes and power-on clear
module dpram_sc #(
    parameter int    ADDR_WIDTH     = 10,
    parameter int    DATA_WIDTH     = 18,
    parameter int    BYTE_SIZE      = 9,
    parameter int    BE_WIDTH       = DATA_WIDTH / BYTE_SIZE,
    parameter string A_WRITE_MODE   = "NORMAL_WRITE",
    parameter string B_WRITE_MODE   = "NORMAL_WRITE",
    parameter int    OUTPUT_REG     = 0,
    parameter int    CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_wr_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic [BE_WIDTH-1:0]   a_wr_byte_en,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  a_rd_valid,
    input  logic                  b_en,
    input  logic                  b_wr_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    input  logic [BE_WIDTH-1:0]   b_wr_byte_en,
    output logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  b_rd_valid,
    output logic                  init_busy,
    output logic                  collision
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  ready;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [1:0]            en;
    logic [1:0]            wr;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [BE_WIDTH-1:0]   be    [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rvalid [2];

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   lane_en
    );
        merge_lanes = old_w;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (lane_en[i]) merge_lanes[i*BYTE_SIZE +: BYTE_SIZE] = new_w[i*BYTE_SIZE +: BYTE_SIZE];
        end
    endfunction

    assign en       = {b_en, a_en};
    assign wr       = {b_wr_en, a_wr_en};
    assign we       = en & wr & {2{ready}};
    assign addr[0]  = a_addr;
    assign addr[1]  = b_addr;
    assign wdata[0] = a_wr_data;
    assign wdata[1] = b_wr_data;
    assign be[0]    = a_wr_byte_en;
    assign be[1]    = b_wr_byte_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (CLEAR_ON_RESET != 0) state <= ST_CLEAR;
            else                     state <= ST_READY;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_READY;
    end

    always_comb begin
        init_busy = (state == ST_CLEAR);
        ready     = (state == ST_READY);
    end

    // Port A is written last so it owns any lane both ports enable on the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (init_busy) mem[clr_cnt] <= '0;
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (we[1] && be[1][i]) mem[addr[1]][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[1][i*BYTE_SIZE +: BYTE_SIZE];
                if (we[0] && be[0][i]) mem[addr[0]][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[0][i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) collision <= 1'b0;
        else      collision <= ready && a_en && b_en && (a_addr == b_addr) && (a_wr_en || b_wr_en);
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam bit TRANSP = (p == 0) ? (A_WRITE_MODE == "TRANSPARENT_WRITE")
                                         : (B_WRITE_MODE == "TRANSPARENT_WRITE");
        localparam bit NORMAL = (p == 0) ? (A_WRITE_MODE == "NORMAL_WRITE")
                                         : (B_WRITE_MODE == "NORMAL_WRITE");

        logic [DATA_WIDTH-1:0] old_word;
        logic [DATA_WIDTH-1:0] s1_data;
        logic                  s1_valid;
        logic                  fire;

        // Array read happens before this edge's writes land, so cross-port reads see the old word.
        assign old_word = mem[addr[p]];
        assign fire     = ready && en[p] && (!wr[p] || !NORMAL);

        always_ff @(posedge clk) begin
            if (!rst) begin
                s1_data  <= '0;
                s1_valid <= 1'b0;
            end else begin
                s1_valid <= fire;
                if (fire) s1_data <= (wr[p] && TRANSP) ? merge_lanes(old_word, wdata[p], be[p]) : old_word;
            end
        end

        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_data  <= s1_data;
                    s2_valid <= s1_valid;
                end
            end

            assign rdata[p]  = s2_data;
            assign rvalid[p] = s2_valid;
        end else begin : g_noreg
            assign rdata[p]  = s1_data;
            assign rvalid[p] = s1_valid;
        end
    end

    assign a_rd_data  = rdata[0];
    assign a_rd_valid = rvalid[0];
    assign b_rd_data  = rdata[1];
    assign b_rd_valid = rvalid[1];

endmodule

// File: tb/tb_dpram_sc.sv
// tb/tb_dpram_sc.sv - scoreboard bench for dpram_sc across three write-mode / output-register builds
module tb_dpram_sc;

    localparam int AW = 4;
    localparam int DW = 18;

    typedef struct {
        int          inst;
        int          port;
        int          due;
        logic [17:0] data;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_en, a_wr_en, b_en, b_wr_en;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wr_data, b_wr_data;
    logic [1:0]    a_wr_byte_en, b_wr_byte_en;

    logic [DW-1:0] a_rd_data [3];
    logic [DW-1:0] b_rd_data [3];
    logic          a_rd_valid [3];
    logic          b_rd_valid [3];
    logic          init_busy [3];
    logic          collision [3];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    sb_t  sb [$];
    bit   coll_exp [int];
    logic [17:0] model [16];

    // mode codes: 0 normal, 1 transparent, 2 read-before-write
    int a_mode [3] = '{0, 1, 2};
    int b_mode [3] = '{2, 0, 2};
    int lat    [3] = '{1, 2, 1};

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        dpram_sc #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(9),
            .A_WRITE_MODE(k == 0 ? "NORMAL_WRITE" : (k == 1 ? "TRANSPARENT_WRITE" : "READ_BEFORE_WRITE")),
            .B_WRITE_MODE(k == 1 ? "NORMAL_WRITE" : "READ_BEFORE_WRITE"),
            .OUTPUT_REG(k == 1 ? 1 : 0), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .a_en(a_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_wr_data(a_wr_data),
            .a_wr_byte_en(a_wr_byte_en), .a_rd_data(a_rd_data[k]), .a_rd_valid(a_rd_valid[k]),
            .b_en(b_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_wr_data(b_wr_data),
            .b_wr_byte_en(b_wr_byte_en), .b_rd_data(b_rd_data[k]), .b_rd_valid(b_rd_valid[k]),
            .init_busy(init_busy[k]), .collision(collision[k])
        );
    end

    function automatic logic [17:0] merge(input logic [17:0] old_w, input logic [17:0] new_w, input logic [1:0] lanes);
        merge = old_w;
        if (lanes[0]) merge[8:0]  = new_w[8:0];
        if (lanes[1]) merge[17:9] = new_w[17:9];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            a_en = 1'b0; b_en = 1'b0;
        end
    endtask

    // Drives one cycle of both ports; when live, pushes expected read results and updates the model.
    task automatic do_op(input bit live, input bit [2:0] keep,
                         input bit ae, input bit aw, input logic [3:0] aa, input logic [17:0] ad, input logic [1:0] ab,
                         input bit ben, input bit bw, input logic [3:0] ba, input logic [17:0] bd, input logic [1:0] bb);
        logic [17:0] old_a, old_b, old_p, dp;
        logic [1:0]  bep;
        bit          enp, wrp, push;
        int          mode;
        sb_t         e;
        @(posedge clk); #1;
        a_en = ae; a_wr_en = aw; a_addr = aa; a_wr_data = ad; a_wr_byte_en = ab;
        b_en = ben; b_wr_en = bw; b_addr = ba; b_wr_data = bd; b_wr_byte_en = bb;
        if (live) begin
            old_a = model[aa];
            old_b = model[ba];
            for (int k = 0; k < 3; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (p == 0) begin enp = ae;  wrp = aw; old_p = old_a; dp = ad; bep = ab; mode = a_mode[k]; end
                    else        begin enp = ben; wrp = bw; old_p = old_b; dp = bd; bep = bb; mode = b_mode[k]; end
                    push = 1'b0;
                    if (keep[k] && enp) begin
                        if (!wrp)           begin push = 1'b1; e.data = old_p; end
                        else if (mode == 1) begin push = 1'b1; e.data = merge(old_p, dp, bep); end
                        else if (mode == 2) begin push = 1'b1; e.data = old_p; end
                    end
                    if (push) begin
                        e.inst = k; e.port = p; e.due = cyc + lat[k];
                        sb.push_back(e);
                    end
                end
            end
            if (ae && ben && aa == ba && (aw || bw)) coll_exp[cyc + 1] = 1'b1;
            if (ben && bw) model[ba] = merge(model[ba], bd, bb);
            if (ae && aw)  model[aa] = merge(model[aa], ad, ab);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_on) begin
                for (int k = 0; k < 3; k++) begin
                    for (int p = 0; p < 2; p++) begin
                        logic        v;
                        logic [17:0] d;
                        int          idx;
                        v = (p == 0) ? a_rd_valid[k] : b_rd_valid[k];
                        d = (p == 0) ? a_rd_data[k]  : b_rd_data[k];
                        if (v === 1'b1) begin
                            idx = -1;
                            for (int i = 0; i < sb.size(); i++)
                                if (idx < 0 && sb[i].inst == k && sb[i].port == p) idx = i;
                            n_cmp++;
                            if (idx < 0) begin
                                n_bad++;
                                $display("FAIL unexpected_rd_valid u%0d port%0d cyc %0d: got data %h, want no valid", k, p, cyc, d);
                            end else begin
                                if (d !== sb[idx].data || cyc != sb[idx].due) begin
                                    n_bad++;
                                    $display("FAIL rd_data u%0d port%0d: got %h at cyc %0d, want %h at cyc %0d",
                                             k, p, d, cyc, sb[idx].data, sb[idx].due);
                                end
                                sb.delete(idx);
                            end
                        end
                    end
                    begin
                        bit ce;
                        ce = coll_exp.exists(cyc) != 0;
                        n_cmp++;
                        if (collision[k] !== ce) begin
                            n_bad++;
                            $display("FAIL collision u%0d cyc %0d: got %b want %b", k, cyc, collision[k], ce);
                        end
                    end
                end
            end
        end
    endtask

    task automatic count_clear(input string name, input int drop_at, input logic [3:0] drop_addr);
        int busy [3];
        busy = '{0, 0, 0};
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (init_busy[k] === 1'b1) busy[k]++;
            if (i == drop_at) begin
                a_en = 1'b1; a_wr_en = 1'b1; a_addr = drop_addr; a_wr_data = 18'h001FF; a_wr_byte_en = 2'b11;
                b_en = 1'b1; b_wr_en = 1'b0; b_addr = drop_addr;
            end else if (i == drop_at + 1) begin
                a_en = 1'b0; b_en = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (busy[k] != 16) begin
                n_bad++;
                $display("FAIL %s_busy_cycles u%0d: got %0d want 16", name, k, busy[k]);
            end
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_en = 1'b0; a_wr_en = 1'b0; a_addr = '0; a_wr_data = '0; a_wr_byte_en = '0;
        b_en = 1'b0; b_wr_en = 1'b0; b_addr = '0; b_wr_data = '0; b_wr_byte_en = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({a_rd_data[k], b_rd_data[k], a_rd_valid[k], b_rd_valid[k], collision[k], init_busy[k]} !== {36'h0, 4'b0001}) begin
                n_bad++;
                $display("FAIL reset_state u%0d: got a=%h b=%h av=%b bv=%b coll=%b busy=%b want zeros busy=1",
                         k, a_rd_data[k], b_rd_data[k], a_rd_valid[k], b_rd_valid[k], collision[k], init_busy[k]);
            end
        end
        mon_on = 1'b1;
    endtask

    task automatic test_clear();
        count_clear("clear", 10, 4'd0);
        for (int i = 0; i < 16; i++) do_op(1, 3'b111, 1, 0, 4'(i), '0, '0, 1, 0, 4'(15 - i), '0, '0);
        idle(3);
    endtask

    task automatic test_byte_enable();
        do_op(1, 3'b111, 1, 1, 4'd5, 18'h3FFFF, 2'b11, 0, 0, '0, '0, '0);
        do_op(1, 3'b111, 1, 1, 4'd5, 18'h00000, 2'b01, 0, 0, '0, '0, '0);
        do_op(1, 3'b111, 1, 0, 4'd5, '0, '0, 0, 0, '0, '0, '0);
        idle(3);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (a_rd_data[k] !== 18'h3FE00) begin
                n_bad++;
                $display("FAIL byte_enable u%0d: got %h want 3fe00", k, a_rd_data[k]);
            end
        end
    endtask

    task automatic test_write_modes();
        logic [17:0] want [3];
        want = '{18'h00011, 18'h00022, 18'h00011};
        do_op(1, 3'b111, 1, 1, 4'd3, 18'h00011, 2'b11, 0, 0, '0, '0, '0);
        do_op(1, 3'b111, 1, 0, 4'd3, '0, '0, 0, 0, '0, '0, '0);
        do_op(1, 3'b111, 1, 1, 4'd3, 18'h00022, 2'b11, 0, 0, '0, '0, '0);
        idle(4);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (a_rd_data[k] !== want[k]) begin
                n_bad++;
                $display("FAIL write_mode u%0d: got %h want %h", k, a_rd_data[k], want[k]);
            end
        end
    endtask

    task automatic test_cross_port();
        do_op(1, 3'b111, 1, 1, 4'd7, 18'h00555, 2'b11, 0, 0, '0, '0, '0);
        do_op(1, 3'b111, 1, 1, 4'd7, 18'h00AAA, 2'b11, 1, 0, 4'd7, '0, '0);
        @(posedge clk);
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (collision[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL cross_port_collision u%0d: got %b want 1", k, collision[k]);
            end
        end
        do_op(1, 3'b111, 1, 0, 4'd7, '0, '0, 0, 0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_dual_write();
        do_op(1, 3'b111, 1, 1, 4'd9, 18'h12345, 2'b11, 1, 1, 4'd9, 18'h3FFFF, 2'b10);
        @(posedge clk);
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (collision[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL dual_write_collision u%0d: got %b want 1", k, collision[k]);
            end
        end
        do_op(1, 3'b111, 0, 0, '0, '0, '0, 1, 0, 4'd9, '0, '0);
        do_op(1, 3'b111, 1, 1, 4'd9, 18'h00000, 2'b01, 1, 1, 4'd9, 18'h3FFFF, 2'b10);
        do_op(1, 3'b111, 1, 0, 4'd9, '0, '0, 0, 0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 150; n++) begin
            bit          ae, aw, ben, bw;
            logic [3:0]  aa, ba;
            logic [17:0] ad, bd;
            logic [1:0]  ab, bb;
            ae = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
            ben = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
            aa = 4'($urandom_range(0, 3)); ba = 4'($urandom_range(0, 3));
            ad = 18'($urandom); bd = 18'($urandom);
            ab = 2'($urandom_range(0, 3)); bb = 2'($urandom_range(0, 3));
            if (ae && aw && ben && bw && aa == ba) bw = 1'b0;
            do_op(1, 3'b111, ae, aw, aa, ad, ab, ben, bw, ba, bd, bb);
        end
        idle(4);
    endtask

    task automatic test_reset_mid_clear();
        do_op(1, 3'b101, 1, 0, 4'd9, '0, '0, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0; a_en = 1'b0; b_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({a_rd_data[k], a_rd_valid[k], b_rd_valid[k]} !== 20'h0) begin
                n_bad++;
                $display("FAIL reset_abort u%0d: got data=%h av=%b bv=%b want zeros", k, a_rd_data[k], a_rd_valid[k], b_rd_valid[k]);
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        count_clear("mid_clear", 12, 4'd1);
        do_op(1, 3'b111, 1, 0, 4'd1, '0, '0, 1, 0, 4'd9, '0, '0);
        idle(3);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_clear();
        test_byte_enable();
        test_write_modes();
        test_cross_port();
        test_dual_write();
        test_back_to_back();
        test_reset_mid_clear();
        idle(2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending reads want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
